qspi_sram_sync: RTL and testbench

QSPI_SRAM_SYNC -- requirements
Module: qspi_sram_sync

---
 rtl/qspi_sram_pkg.sv | 26 ++
 rtl/qspi_sram_sync_edge.sv | 43 ++++
 rtl/qspi_sram_sync.sv | 209 ++++++++++++++++++++
 tb/tb_qspi_sram_sync.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_sram_pkg.sv
// Shared types and default opcodes for the QSPI-attached SRAM slave.
package qspi_sram_pkg;

    // Frame-level protocol state of the slave.
    typedef enum logic [2:0] {
        ST_CMD   = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4,
        ST_FAIL  = 3'd5
    } state_t;

    localparam logic [7:0] OP_READ       = 8'h03;
    localparam logic [7:0] OP_WRITE      = 8'h02;
    localparam logic [7:0] OP_READ_QUAD  = 8'hEB;
    localparam logic [7:0] OP_WRITE_QUAD = 8'h38;
    localparam logic [7:0] OP_EQIO       = 8'h35;
    localparam logic [7:0] OP_RSTQIO     = 8'hF5;

    // Number of bits consumed or produced on one sck rise.
    function automatic logic [4:0] bits_per_rise(input logic i_quad);
        return i_quad ? 5'd4 : 5'd1;
    endfunction

endpackage

// File: rtl/qspi_sram_sync_edge.sv
// Two-flop synchroniser for the SPI pins plus sck rising-edge detector.
// sck, ss_n and sio all take the same two-stage path so they stay aligned.
module qspi_sram_sync_edge (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sck,
    input  logic       i_ss_n,
    input  logic [3:0] i_sio,
    output logic       o_sck_rise,
    output logic       o_ss_n,
    output logic [3:0] o_sio
);

    logic       r_sck_m, r_sck_s, r_sck_prev;
    logic       r_ss_m, r_ss_s;
    logic [3:0] r_sio_m, r_sio_s;

    // Synchronise pins into clk domain and keep last synchronised sck.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sck_m    <= 1'b0;
            r_sck_s    <= 1'b0;
            r_sck_prev <= 1'b0;
            r_ss_m     <= 1'b1;
            r_ss_s     <= 1'b1;
            r_sio_m    <= 4'h0;
            r_sio_s    <= 4'h0;
        end else begin
            r_sck_m    <= i_sck;
            r_sck_s    <= r_sck_m;
            r_sck_prev <= r_sck_s;
            r_ss_m     <= i_ss_n;
            r_ss_s     <= r_ss_m;
            r_sio_m    <= i_sio;
            r_sio_s    <= r_sio_m;
        end
    end

    assign o_sck_rise = r_sck_s & ~r_sck_prev;
    assign o_ss_n     = r_ss_s;
    assign o_sio      = r_sio_s;

endmodule

// File: rtl/qspi_sram_sync.sv
// SPI/QPI SRAM slave sampled in the clk domain. One action per detected sck
// rise: shift in opcode/address/write data, or drive the next read bit/nibble.
// Outputs are registered, so they change on the same clk as the rise is seen.
module qspi_sram_sync
    import qspi_sram_pkg::*;
#(
    parameter int         ADDR_BITS      = 24,
    parameter int         DEPTH_LOG2     = 16,
    parameter int         WAIT_CYCLES    = 4,
    parameter logic [7:0] CMD_READ       = OP_READ,
    parameter logic [7:0] CMD_WRITE      = OP_WRITE,
    parameter logic [7:0] CMD_READ_QUAD  = OP_READ_QUAD,
    parameter logic [7:0] CMD_WRITE_QUAD = OP_WRITE_QUAD,
    parameter logic [7:0] CMD_EQIO       = OP_EQIO,
    parameter logic [7:0] CMD_RSTQIO     = OP_RSTQIO
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sck,
    input  logic       ss_n,
    input  logic [3:0] sio_in,
    output logic [3:0] sio_out,
    output logic [3:0] sio_oe
);

    localparam logic [4:0] ADDR_CNT = 5'(ADDR_BITS);
    localparam logic [4:0] WAIT_CNT = 5'(WAIT_CYCLES);

    logic                  w_rise, w_ss_n;
    logic [3:0]            w_sio;

    state_t                r_state, w_state_nxt;
    logic                  r_qpi, w_qpi_nxt;
    logic                  r_quad, w_quad_nxt;       // 4 bits/rise after the opcode
    logic                  r_is_read, w_is_read_nxt;
    logic                  r_is_qread, w_is_qread_nxt; // quad read opcode: needs dummy rises
    logic [4:0]            r_cnt, w_cnt_nxt;
    logic [ADDR_BITS-1:0]  r_shift, w_shift_nxt;
    logic [DEPTH_LOG2-1:0] r_addr, w_addr_nxt;
    logic [3:0]            r_sio_out, w_sio_out_nxt;
    logic [3:0]            r_sio_oe, w_sio_oe_nxt;

    logic [7:0]            r_mem [0:(1<<DEPTH_LOG2)-1];
    logic                  w_mem_we;

    logic                  w_bits_quad;
    logic [4:0]            w_cnt_inc;
    logic [ADDR_BITS-1:0]  w_shift_in;
    logic [7:0]            w_rd_byte;

    qspi_sram_sync_edge u_edge (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_sck      (sck),
        .i_ss_n     (ss_n),
        .i_sio      (sio_in),
        .o_sck_rise (w_rise),
        .o_ss_n     (w_ss_n),
        .o_sio      (w_sio)
    );

    // The opcode width follows the QPI flag; everything after it follows r_quad.
    assign w_bits_quad = (r_state == ST_CMD) ? r_qpi : r_quad;
    assign w_cnt_inc   = r_cnt + bits_per_rise(w_bits_quad);
    assign w_shift_in  = w_bits_quad ? {r_shift[ADDR_BITS-5:0], w_sio}
                                     : {r_shift[ADDR_BITS-2:0], w_sio[0]};
    assign w_rd_byte   = r_mem[r_addr];

    // Register protocol state and outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_CMD;
            r_qpi      <= 1'b0;
            r_quad     <= 1'b0;
            r_is_read  <= 1'b0;
            r_is_qread <= 1'b0;
            r_cnt      <= 5'd0;
            r_shift    <= '0;
            r_addr     <= '0;
            r_sio_out  <= 4'h0;
            r_sio_oe   <= 4'h0;
        end else begin
            r_state    <= w_state_nxt;
            r_qpi      <= w_qpi_nxt;
            r_quad     <= w_quad_nxt;
            r_is_read  <= w_is_read_nxt;
            r_is_qread <= w_is_qread_nxt;
            r_cnt      <= w_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_addr     <= w_addr_nxt;
            r_sio_out  <= w_sio_out_nxt;
            r_sio_oe   <= w_sio_oe_nxt;
        end
    end

    // Next-state, datapath and output decode for one sck rise or a deselect.
    always_comb begin
        w_state_nxt    = r_state;
        w_qpi_nxt      = r_qpi;
        w_quad_nxt     = r_quad;
        w_is_read_nxt  = r_is_read;
        w_is_qread_nxt = r_is_qread;
        w_cnt_nxt      = r_cnt;
        w_shift_nxt    = r_shift;
        w_addr_nxt     = r_addr;
        w_sio_out_nxt  = r_sio_out;
        w_sio_oe_nxt   = r_sio_oe;
        w_mem_we       = 1'b0;

        if (w_ss_n) begin
            w_state_nxt   = ST_CMD;
            w_cnt_nxt     = 5'd0;
            w_shift_nxt   = '0;
            w_sio_out_nxt = 4'h0;
            w_sio_oe_nxt  = 4'h0;
        end else if (w_rise) begin
            w_sio_out_nxt = 4'h0;
            w_sio_oe_nxt  = 4'h0;
            case (r_state)
                ST_CMD: begin
                    w_shift_nxt = w_shift_in;
                    w_cnt_nxt   = w_cnt_inc;
                    if (w_cnt_inc == 5'd8) begin
                        w_cnt_nxt      = 5'd0;
                        w_state_nxt    = ST_ADDR;
                        w_is_qread_nxt = 1'b0;
                        if (w_shift_in[7:0] == CMD_READ) begin
                            w_quad_nxt    = r_qpi;
                            w_is_read_nxt = 1'b1;
                        end else if (w_shift_in[7:0] == CMD_READ_QUAD) begin
                            w_quad_nxt     = 1'b1;
                            w_is_read_nxt  = 1'b1;
                            w_is_qread_nxt = 1'b1;
                        end else if (w_shift_in[7:0] == CMD_WRITE) begin
                            w_quad_nxt    = r_qpi;
                            w_is_read_nxt = 1'b0;
                        end else if (w_shift_in[7:0] == CMD_WRITE_QUAD) begin
                            w_quad_nxt    = 1'b1;
                            w_is_read_nxt = 1'b0;
                        end else if (w_shift_in[7:0] == CMD_EQIO) begin
                            w_qpi_nxt   = 1'b1;
                            w_state_nxt = ST_FAIL;
                        end else if (w_shift_in[7:0] == CMD_RSTQIO) begin
                            w_qpi_nxt   = 1'b0;
                            w_state_nxt = ST_FAIL;
                        end else begin
                            w_state_nxt = ST_FAIL;
                        end
                    end
                end
                ST_ADDR: begin
                    w_shift_nxt = w_shift_in;
                    w_cnt_nxt   = w_cnt_inc;
                    if (w_cnt_inc == ADDR_CNT) begin
                        w_cnt_nxt  = 5'd0;
                        w_addr_nxt = w_shift_in[DEPTH_LOG2-1:0];
                        if (!r_is_read)
                            w_state_nxt = ST_WRITE;
                        else if (r_is_qread && (WAIT_CYCLES != 0))
                            w_state_nxt = ST_WAIT;
                        else
                            w_state_nxt = ST_READ;
                    end
                end
                ST_WAIT: begin
                    w_cnt_nxt = r_cnt + 5'd1;
                    if (r_cnt + 5'd1 == WAIT_CNT) begin
                        w_cnt_nxt   = 5'd0;
                        w_state_nxt = ST_READ;
                    end
                end
                ST_READ: begin
                    w_cnt_nxt = w_cnt_inc;
                    if (r_quad) begin
                        w_sio_out_nxt = r_cnt[2] ? w_rd_byte[3:0] : w_rd_byte[7:4];
                        w_sio_oe_nxt  = 4'b1111;
                    end else begin
                        w_sio_out_nxt = {2'b00, w_rd_byte[3'd7 - r_cnt[2:0]], 1'b0};
                        w_sio_oe_nxt  = 4'b0010;
                    end
                    if (w_cnt_inc == 5'd8) begin
                        w_cnt_nxt  = 5'd0;
                        w_addr_nxt = r_addr + DEPTH_LOG2'(1);
                    end
                end
                ST_WRITE: begin
                    w_shift_nxt = w_shift_in;
                    w_cnt_nxt   = w_cnt_inc;
                    if (w_cnt_inc == 5'd8) begin
                        w_mem_we   = 1'b1;
                        w_cnt_nxt  = 5'd0;
                        w_addr_nxt = r_addr + DEPTH_LOG2'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Byte commit into the storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we)
            r_mem[r_addr] <= w_shift_in[7:0];
    end

    assign sio_out = r_sio_out;
    assign sio_oe  = r_sio_oe;

endmodule

// File: tb/tb_qspi_sram_sync.sv
// Bench for qspi_sram_sync: a transaction-level memory model predicts the
// output after every sck rise; a monitor compares 3 clk after each rise.
module tb_qspi_sram_sync;

  localparam int AB    = 24;
  localparam int DL    = 16;
  localparam int WC    = 4;
  localparam int DEPTH = 1 << DL;

  localparam logic [7:0] C_READ   = 8'h03;
  localparam logic [7:0] C_WRITE  = 8'h02;
  localparam logic [7:0] C_QREAD  = 8'hEB;
  localparam logic [7:0] C_QWRITE = 8'h38;
  localparam logic [7:0] C_EQIO   = 8'h35;
  localparam logic [7:0] C_RSTQIO = 8'hF5;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0;
  logic       ss_n = 1'b1;
  logic [3:0] sio_in = 4'h0;
  logic [3:0] sio_out, sio_oe;

  always #5 clk = ~clk;

  qspi_sram_sync #(
    .ADDR_BITS  (AB),
    .DEPTH_LOG2 (DL),
    .WAIT_CYCLES(WC)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sck    (sck),
    .ss_n   (ss_n),
    .sio_in (sio_in),
    .sio_out(sio_out),
    .sio_oe (sio_oe)
  );

  // scoreboard state: {check_out, oe[3:0], out[3:0]}
  logic [8:0] exp_q[$];
  string      tag_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  // reference model
  logic [7:0] mem_model[int];
  bit         model_qpi = 1'b0;
  logic [7:0] wr_data[$];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // driver: one sck pulse, expectation queued before the rise
  task automatic rise(input logic [3:0] din, input logic chk_out,
                      input logic [3:0] e_oe, input logic [3:0] e_out, input string tag);
    exp_q.push_back({chk_out, e_oe, e_out});
    tag_q.push_back(tag);
    @(negedge clk) sio_in = din;
    @(negedge clk) sck = 1'b1;
    repeat (4) @(negedge clk);
    sck = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic idle_rise(input logic [3:0] din, input string tag);
    rise(din, 1'b1, 4'h0, 4'h0, tag);
  endtask

  task automatic send_bits(input logic [31:0] val, input int nbits, input bit quad, input string tag);
    if (quad) begin
      for (int i = nbits/4 - 1; i >= 0; i--) idle_rise(val[i*4 +: 4], tag);
    end else begin
      for (int i = nbits - 1; i >= 0; i--) idle_rise({3'($urandom), val[i]}, tag);
    end
  endtask

  task automatic select_dev();
    @(negedge clk) ss_n = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic deselect_dev();
    @(negedge clk) ss_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("deselect_oe", sio_oe, 4'h0);
    chk("deselect_out", sio_out, 4'h0);
  endtask

  task automatic send_cmd(input logic [7:0] op);
    send_bits({24'h0, op}, 8, model_qpi, "cmd");
  endtask

  function automatic int wrap_addr(input logic [23:0] addr, input int k);
    return (int'(addr[DL-1:0]) + k) % DEPTH;
  endfunction

  // write frame: data from wr_data, optional trailing partial byte
  task automatic frame_write(input logic [7:0] op, input logic [23:0] addr, input int partial_bits);
    bit quad;
    quad = model_qpi || (op == C_QWRITE);
    select_dev();
    send_cmd(op);
    send_bits({8'h0, addr}, AB, quad, "addr");
    for (int k = 0; k < wr_data.size(); k++) begin
      send_bits({24'h0, wr_data[k]}, 8, quad, "wdata");
      mem_model[wrap_addr(addr, k)] = wr_data[k];
    end
    if (partial_bits > 0) send_bits(32'($urandom), quad ? 4 : partial_bits, quad, "wpartial");
    deselect_dev();
  endtask

  // read frame: expected bits/nibbles come from the memory model
  task automatic frame_read(input logic [7:0] op, input logic [23:0] addr, input int nbytes);
    bit         quad, known;
    logic [7:0] b;
    int         a;
    quad = model_qpi || (op == C_QREAD);
    select_dev();
    send_cmd(op);
    send_bits({8'h0, addr}, AB, quad, "addr");
    if (op == C_QREAD) repeat (WC) idle_rise(4'($urandom), "wait");
    for (int k = 0; k < nbytes; k++) begin
      a = wrap_addr(addr, k);
      known = mem_model.exists(a);
      b = known ? mem_model[a] : 8'h00;
      if (quad) begin
        rise(4'($urandom), known, 4'b1111, b[7:4], "rd_hi");
        rise(4'($urandom), known, 4'b1111, b[3:0], "rd_lo");
      end else begin
        for (int i = 7; i >= 0; i--)
          rise(4'($urandom), known, 4'b0010, {2'b00, b[i], 1'b0}, "rd_bit");
      end
    end
    deselect_dev();
  endtask

  // monitor: compare registered outputs 3 clk after every sck pin rise
  initial begin : monitor
    logic [8:0] e;
    string      t;
    forever begin
      @(posedge sck);
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_rise: oe=%b out=%b with no expectation", sio_oe, sio_out);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (sio_oe !== e[7:4] || (e[8] && sio_out !== e[3:0])) begin
          n_errors++;
          $display("FAIL %s: oe=%b out=%b, expected oe=%b out=%b%s",
                   t, sio_oe, sio_out, e[7:4], e[3:0], e[8] ? "" : " (out not checked)");
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: run did not complete, %0d expectations pending", exp_q.size());
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0]  b;
    logic [23:0] addr;
    int          n;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_oe", sio_oe, 4'h0);
    chk("reset_out", sio_out, 4'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // single write then single read
    wr_data = '{8'hA5, 8'h3C};
    frame_write(C_WRITE, 24'h000010, 0);
    frame_read(C_READ, 24'h000010, 2);

    // quad write then quad read with dummy rises
    wr_data = '{8'hDE, 8'hAD};
    frame_write(C_QWRITE, 24'h001234, 0);
    frame_read(C_QREAD, 24'h001234, 2);

    // address wrap at top of memory
    wr_data = '{8'h11, 8'h22};
    frame_write(C_WRITE, 24'h00FFFF, 0);
    frame_read(C_READ, 24'h000000, 1);
    frame_read(C_READ, 24'h00FFFF, 2);

    // upper address bits are ignored
    wr_data = '{8'h77};
    frame_write(C_WRITE, 24'hAB0400, 0);
    frame_read(C_READ, 24'h000400, 1);

    // partial byte at deselect is discarded
    wr_data = '{8'h5A};
    frame_write(C_WRITE, 24'h000300, 0);
    wr_data.delete();
    frame_write(C_WRITE, 24'h000300, 4);
    frame_read(C_READ, 24'h000300, 1);

    // QPI entry, quad traffic with 4-bit opcodes, then exit
    select_dev();
    send_cmd(C_EQIO);
    model_qpi = 1'b1;
    repeat (4) idle_rise(4'($urandom), "fail_tail");
    deselect_dev();
    frame_read(C_QREAD, 24'h001234, 2);
    wr_data = '{8'hC3, 8'h96};
    frame_write(C_QWRITE, 24'h002000, 0);
    frame_read(C_QREAD, 24'h002000, 2);
    select_dev();
    send_cmd(C_RSTQIO);
    model_qpi = 1'b0;
    deselect_dev();
    frame_read(C_READ, 24'h002000, 2);

    // unknown opcode keeps the bus released
    select_dev();
    send_cmd(8'h9F);
    repeat (32) idle_rise(4'($urandom), "unknown_op");
    deselect_dev();

    // reset in the middle of a read
    select_dev();
    send_cmd(C_READ);
    send_bits(32'h000010, AB, 1'b0, "addr");
    b = mem_model[16];
    for (int i = 7; i >= 4; i--)
      rise(4'($urandom), 1'b1, 4'b0010, {2'b00, b[i], 1'b0}, "rd_pre_reset");
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midread_reset_oe", sio_oe, 4'h0);
    chk("midread_reset_out", sio_out, 4'h0);
    @(negedge clk);
    ss_n = 1'b1;
    rst_n = 1'b1;
    model_qpi = 1'b0;
    repeat (4) @(negedge clk);
    frame_read(C_READ, 24'h000010, 2);

    // randomized traffic near both ends of the array
    for (int it = 0; it < 10; it++) begin
      addr = {8'($urandom), ($urandom_range(0, 1) ? 16'h0000 : 16'hFFF0) + 16'($urandom_range(0, 15))};
      n = $urandom_range(1, 4);
      wr_data.delete();
      for (int k = 0; k < n; k++) wr_data.push_back(8'($urandom));
      frame_write($urandom_range(0, 1) ? C_WRITE : C_QWRITE, addr, 0);
      addr = {8'($urandom), ($urandom_range(0, 1) ? 16'h0000 : 16'hFFF0) + 16'($urandom_range(0, 15))};
      frame_read($urandom_range(0, 1) ? C_READ : C_QREAD, addr, $urandom_range(1, 4));
    end

    // final report
    repeat (10) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL pending_expectations: got %0d left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
